lab_gate_requester: RTL and testbench
=====================================

Name: lab_gate_requester

Overview:
- Door-side front end for the lab occupancy controller; it is the initiator of the enter/exit request that the controller answers.
- Deserialises a smart-card code from the badge reader and issues a single-cycle enter/exit request (smartCode, lab, mode) to the controller.
- Waits for the controller's unlock/warning response for the selected lab, then drives the door strike for a fixed hold time or reports denial/timeout.
- One instance per reader; its outputs wire directly to the controller's inputs.

Parameters:
- CODE_W, 5, smart-code width in bits.
- OPEN_CYCLES, 8, number of cycles doorOpen stays high after an unlock (must be >= 1).
- RESP_TIMEOUT, 4, maximum number of WAIT cycles before the request is abandoned (must be >= 1).

Ports:
- CLK  in  1  clock, all logic on posedge.
- RST  in  1  reset, synchronous, active-high.
- cardStart  in  1  pulse that begins a frame; labIn and dirIn are sampled in the same cycle.
- cardValid  in  1  cardBit is valid this cycle.
- cardBit  in  1  serial code bit, MSB first.
- labIn  in  1  0: Digital, 1: Mera.
- dirIn  in  1  0: exit, 1: enter.
- unlockDigital, unlockMera  in  1  controller responses.
- restrictionWarnDigital, restrictionWarnMera  in  1  controller responses.
- smartCode  out  CODE_W  assembled code to the controller.
- lab  out  1  lab select to the controller.
- mode  out  2  00: exit, 01: enter, 10: idle.
- busy  out  1  high in any state other than IDLE.
- doorOpen  out  1  door strike drive.
- denied  out  1  one-cycle pulse on restriction warning.
- timeout  out  1  one-cycle pulse when no response arrives.
- dropped  out  1  one-cycle pulse when cardStart is ignored.

Behaviour:
- Reset (RST high at posedge):
  - State returns to IDLE.
  - smartCode=0, lab=0, mode=2'b10, busy=0, doorOpen=0, denied=0, timeout=0, dropped=0.
  - Bit counter and timers clear.
  - Reset mid-operation abandons everything immediately; no request is re-issued.
- mode is 2'b10 in every cycle except the REQ cycle.
- States:
  - IDLE: on cardStart, capture labIn and dirIn, clear the shift register and bit count, go to SHIFT.
  - SHIFT:
    - Each cycle with cardValid: shift register becomes {shift[CODE_W-2:0], cardBit}, count increments.
    - When the CODE_W-th bit is accepted, go to REQ on the next edge.
    - cardStart in SHIFT restarts the frame (re-capture lab and dir, count=0), even if it coincides with cardValid.
    - cardValid without a preceding cardStart while in IDLE is ignored.
  - REQ: exactly one cycle.
    - smartCode = shift register, lab = captured lab, mode = {1'b0, dir}.
    - smartCode and lab hold their values after REQ until the next REQ.
    - Next state is WAIT, with the timeout counter set to 0.
  - WAIT: sample only the response pair for the captured lab. Priority order:
    - unlock=1 → OPEN.
    - warn=1 (unlock=0) → denied=1 for one cycle, then IDLE.
    - Neither: counter increments. When the counter reaches RESP_TIMEOUT, timeout=1 for one cycle, then IDLE. This covers a full lab, which produces no response.
    - Responses for the other lab are ignored.
  - OPEN:
    - doorOpen=1 for exactly OPEN_CYCLES cycles, starting in the cycle after the unlock was sampled; then IDLE.
    - doorOpen is a registered output, never combinational from unlock.
- Response timing:
  - The controller registers its outputs on the edge that samples REQ.
  - Its responses are therefore visible in the first WAIT cycle.
  - The minimum sampled response latency is 1 cycle after REQ.
- cardStart in REQ, WAIT or OPEN is ignored and produces dropped=1 that cycle; state is unaffected.
- denied, timeout and dropped are mutually independent single-cycle pulses; denied and timeout can never assert together.
- Back-to-back use: cardStart is accepted in the first IDLE cycle after OPEN, deny or timeout.

Decomposition:
- Shared package lab_access_pkg:
  - Mode encodings MODE_EXIT=2'b00, MODE_ENTER=2'b01, MODE_IDLE=2'b10.
  - LAB_DIGITAL=0, LAB_MERA=1.
  - Requester state enum IDLE/SHIFT/REQ/WAIT/OPEN.
  - CODE_W default.
- Sub-module card_deser:
  - Shift register plus bit counter.
  - Inputs: start, valid, bit.
  - Outputs: code and a one-cycle done pulse.
- The FSM, timers and response muxing stay in the top module.

Test Plan:
- Enter Digital:
  - Stimulus: cardStart with labIn=0, dirIn=1, bits 1,0,1,1,0; unlockDigital=1 in the first WAIT cycle.
  - Response: one REQ cycle with smartCode=5'b10110, lab=0, mode=01; doorOpen high for 8 cycles; busy falls in the cycle after the last doorOpen cycle.
- Mera restriction:
  - Stimulus: labIn=1, dirIn=1, code 5'b00011; restrictionWarnMera=1 two cycles after REQ.
  - Response: denied pulses once; doorOpen stays 0; back in IDLE.
- Timeout:
  - Stimulus: labIn=0, dirIn=0, code 5'b11111; no responses; also pulse unlockMera during WAIT.
  - Response: mode=00 in the REQ cycle; timeout pulses after 4 WAIT cycles; the unlockMera pulse is ignored.
- Frame restart:
  - Stimulus: 3 bits shifted, then cardStart with labIn=1, then 5 fresh bits 0,1,0,0,1.
  - Response: a single request with smartCode=5'b01001, lab=1; no request for the partial frame.
- Dropped start and reset:
  - Stimulus: cardStart during OPEN.
  - Response: dropped=1 and doorOpen continues uninterrupted.
  - Stimulus: RST asserted in WAIT.
  - Response: next cycle is IDLE with mode=10 and all outputs at their reset values.
- Gapped bits:
  - Stimulus: cardValid asserted every third cycle.
  - Response: the code still assembles correctly, and REQ occurs exactly one cycle after the fifth valid bit.

Source files
------------

// File: rtl/lab_access_pkg.sv
// lab_access_pkg: shared encodings and requester state type for the lab access front end
package lab_access_pkg;
    localparam int CODE_W_DEF = 5;
    localparam logic [1:0] MODE_EXIT = 2'b00;
    localparam logic [1:0] MODE_ENTER = 2'b01;
    localparam logic [1:0] MODE_IDLE = 2'b10;
    localparam logic LAB_DIGITAL = 1'b0;
    localparam logic LAB_MERA = 1'b1;
    typedef enum logic [2:0] {IDLE, SHIFT, REQ, WAIT, OPEN} req_state_t;
endpackage

// File: rtl/card_deser.sv
// card_deser: MSB-first shift register with bit counter and a done strobe on the last accepted bit
module card_deser #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         valid,
    input  logic         sbit,
    output logic [W-1:0] code,
    output logic         done
);
    localparam int CW = $clog2(W + 1);
    logic [CW-1:0] cnt;
    // start wins over a coincident valid, so that bit is discarded
    assign done = valid && !start && cnt == CW'(W - 1);
    always_ff @(posedge clk) begin
        if (rst || start) begin
            code <= '0;
            cnt  <= '0;
        end else if (valid) begin
            code <= {code[W-2:0], sbit};
            cnt  <= done ? '0 : cnt + 1'b1;
        end
    end
endmodule

// File: rtl/lab_gate_requester.sv
// lab_gate_requester: deserialises a badge code, issues one enter/exit request and
// drives the door strike from the controller's answer for the selected lab
module lab_gate_requester
    import lab_access_pkg::*;
#(
    parameter int CODE_W = lab_access_pkg::CODE_W_DEF,
    parameter int OPEN_CYCLES = 8,
    parameter int RESP_TIMEOUT = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              cardStart,
    input  logic              cardValid,
    input  logic              cardBit,
    input  logic              labIn,
    input  logic              dirIn,
    input  logic              unlockDigital,
    input  logic              unlockMera,
    input  logic              restrictionWarnDigital,
    input  logic              restrictionWarnMera,
    output logic [CODE_W-1:0] smartCode,
    output logic              lab,
    output logic [1:0]        mode,
    output logic              busy,
    output logic              doorOpen,
    output logic              denied,
    output logic              timeout,
    output logic              dropped
);
    localparam int TMAX = OPEN_CYCLES > RESP_TIMEOUT ? OPEN_CYCLES : RESP_TIMEOUT;
    localparam int TW = $clog2(TMAX) + 1;
    req_state_t state, next;
    logic lab_cap, dir_cap, lab_q, start_ok, done, unlock, warn;
    logic [CODE_W-1:0] code, code_q;
    logic [TW-1:0] tmr;
    assign start_ok = cardStart && (state == IDLE || state == SHIFT);
    assign unlock = lab_cap == LAB_MERA ? unlockMera : unlockDigital;
    assign warn = lab_cap == LAB_MERA ? restrictionWarnMera : restrictionWarnDigital;
    card_deser #(.W(CODE_W)) u_deser (
        .clk  (CLK),
        .rst  (RST),
        .start(start_ok),
        .valid(cardValid && state == SHIFT),
        .sbit (cardBit),
        .code (code),
        .done (done)
    );
    always_comb begin
        next = state;
        case (state)
            IDLE:  next = cardStart ? SHIFT : IDLE;
            SHIFT: next = done ? REQ : SHIFT;
            REQ:   next = WAIT;
            WAIT:  next = unlock ? OPEN : (warn || tmr == TW'(RESP_TIMEOUT - 1)) ? IDLE : WAIT;
            OPEN:  next = tmr == TW'(OPEN_CYCLES - 1) ? IDLE : OPEN;
            default: next = IDLE;
        endcase
    end
    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= IDLE;
            lab_cap  <= 1'b0;
            dir_cap  <= 1'b0;
            lab_q    <= 1'b0;
            code_q   <= '0;
            tmr      <= '0;
            doorOpen <= 1'b0;
            denied   <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            state <= next;
            tmr   <= (next == state && (state == WAIT || state == OPEN)) ? tmr + 1'b1 : '0;
            if (start_ok) begin
                lab_cap <= labIn;
                dir_cap <= dirIn;
            end
            if (state == REQ) begin
                code_q <= code;
                lab_q  <= lab_cap;
            end
            doorOpen <= next == OPEN;
            denied   <= state == WAIT && !unlock && warn;
            timeout  <= state == WAIT && !unlock && !warn && tmr == TW'(RESP_TIMEOUT - 1);
        end
    end
    // request fields are live during REQ and then held until the next request
    assign smartCode = state == REQ ? code : code_q;
    assign lab = state == REQ ? lab_cap : lab_q;
    assign mode = state == REQ ? {1'b0, dir_cap} : MODE_IDLE;
    assign busy = state != IDLE;
    assign dropped = cardStart && !start_ok;
endmodule

// File: tb/tb_lab_gate_requester.sv
// tb_lab_gate_requester: directed-step bench for lab_gate_requester with hand-computed expectations
module tb_lab_gate_requester;
    logic CLK = 1'b0, RST = 1'b1;
    logic cardStart = 0, cardValid = 0, cardBit = 0, labIn = 0, dirIn = 0;
    logic unlockDigital = 0, unlockMera = 0, restrictionWarnDigital = 0, restrictionWarnMera = 0;
    logic [4:0] smartCode;
    logic lab, busy, doorOpen, denied, timeout, dropped;
    logic [1:0] mode;
    int checks = 0, errors = 0;

    always #5 CLK = ~CLK;

    lab_gate_requester dut (
        .CLK(CLK), .RST(RST), .cardStart(cardStart), .cardValid(cardValid), .cardBit(cardBit),
        .labIn(labIn), .dirIn(dirIn), .unlockDigital(unlockDigital), .unlockMera(unlockMera),
        .restrictionWarnDigital(restrictionWarnDigital), .restrictionWarnMera(restrictionWarnMera),
        .smartCode(smartCode), .lab(lab), .mode(mode), .busy(busy), .doorOpen(doorOpen),
        .denied(denied), .timeout(timeout), .dropped(dropped)
    );

    task automatic nxt();
        @(posedge CLK);
        #2;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_frame(input logic l, input logic d, input logic [4:0] c, input int gap);
        cardStart = 1; labIn = l; dirIn = d;
        nxt();
        cardStart = 0;
        for (int i = 0; i < 5; i++) begin
            cardValid = 1; cardBit = c[4-i];
            nxt();
            cardValid = 0;
            if (i < 4) repeat (gap) nxt();
        end
    endtask

    initial begin
        nxt(); nxt();
        chk("rst_mode", mode, 2'b10);
        chk("rst_busy", busy, 0);
        chk("rst_code", smartCode, 0);
        chk("rst_outs", {doorOpen, denied, timeout, dropped, lab}, 0);
        RST = 0;
        // stray valid bits in IDLE are ignored
        cardValid = 1; cardBit = 1; nxt(); nxt(); cardValid = 0; nxt();
        chk("idle_valid_busy", busy, 0);

        // enter Digital, unlocked in first WAIT cycle, dropped start during OPEN
        send_frame(0, 1, 5'b10110, 0);
        chk("ed_req_code", smartCode, 5'b10110);
        chk("ed_req_lab", lab, 0);
        chk("ed_req_mode", mode, 2'b01);
        nxt();
        unlockDigital = 1;
        chk("ed_wait_mode", mode, 2'b10);
        chk("ed_wait_door", doorOpen, 0);
        chk("ed_hold_code", smartCode, 5'b10110);
        nxt();
        unlockDigital = 0;
        for (int k = 0; k < 8; k++) begin
            if (k == 2) begin
                cardStart = 1; #1;
                chk("ed_dropped", dropped, 1);
            end
            chk("ed_door", doorOpen, 1);
            chk("ed_busy", busy, 1);
            nxt();
            cardStart = 0;
        end
        chk("ed_end_door", doorOpen, 0);
        chk("ed_end_busy", busy, 0);
        chk("ed_end_dropped", dropped, 0);

        // Mera restriction, back-to-back; Digital unlock in w1 must be ignored
        send_frame(1, 1, 5'b00011, 0);
        chk("mr_req_code", smartCode, 5'b00011);
        chk("mr_req_lab", lab, 1);
        chk("mr_req_mode", mode, 2'b01);
        nxt();
        unlockDigital = 1;
        nxt();
        unlockDigital = 0; restrictionWarnMera = 1;
        chk("mr_w2_busy", busy, 1);
        chk("mr_w2_door", doorOpen, 0);
        nxt();
        restrictionWarnMera = 0;
        chk("mr_denied", denied, 1);
        chk("mr_busy", busy, 0);
        chk("mr_door", doorOpen, 0);
        nxt();
        chk("mr_denied_once", {denied, doorOpen}, 0);

        // timeout with a stray Mera unlock
        send_frame(0, 0, 5'b11111, 0);
        chk("to_req_mode", mode, 2'b00);
        chk("to_req_code", smartCode, 5'b11111);
        chk("to_req_lab", lab, 0);
        nxt(); nxt();
        unlockMera = 1;
        nxt();
        unlockMera = 0;
        chk("to_w3_busy", busy, 1);
        nxt();
        chk("to_w4_timeout", timeout, 0);
        chk("to_w4_busy", busy, 1);
        nxt();
        chk("to_timeout", timeout, 1);
        chk("to_busy", busy, 0);
        chk("to_other", {doorOpen, denied}, 0);
        nxt();
        chk("to_once", timeout, 0);

        // frame restart after 3 bits, restart coincides with a valid bit
        cardStart = 1; labIn = 0; dirIn = 1;
        nxt();
        cardStart = 0;
        for (int i = 0; i < 3; i++) begin
            cardValid = 1; cardBit = 1;
            nxt();
            chk("fr_partial_mode", mode, 2'b10);
        end
        cardStart = 1; labIn = 1; cardValid = 1; cardBit = 1;
        nxt();
        cardStart = 0;
        for (int i = 0; i < 5; i++) begin
            cardBit = (5'b01001 >> (4 - i)) & 1;
            cardValid = 1;
            if (i < 4) begin
                nxt();
                chk("fr_shift_mode", mode, 2'b10);
            end else nxt();
        end
        cardValid = 0;
        chk("fr_req_code", smartCode, 5'b01001);
        chk("fr_req_lab", lab, 1);
        chk("fr_req_mode", mode, 2'b01);
        nxt();
        chk("fr_wait_mode", mode, 2'b10);
        // reset while waiting
        RST = 1;
        nxt();
        RST = 0;
        chk("rw_busy", busy, 0);
        chk("rw_mode", mode, 2'b10);
        chk("rw_code", smartCode, 0);
        chk("rw_outs", {doorOpen, denied, timeout, dropped, lab}, 0);
        nxt();
        chk("rw_no_reissue", {mode, busy}, 3'b100);

        // gapped bits, then simultaneous unlock and warn: unlock wins
        send_frame(0, 1, 5'b01101, 2);
        chk("gp_req_mode", mode, 2'b01);
        chk("gp_req_code", smartCode, 5'b01101);
        nxt();
        unlockDigital = 1; restrictionWarnDigital = 1;
        nxt();
        unlockDigital = 0; restrictionWarnDigital = 0;
        chk("gp_open", doorOpen, 1);
        chk("gp_not_denied", denied, 0);
        repeat (7) nxt();
        chk("gp_last_door", doorOpen, 1);
        nxt();
        chk("gp_door_off", {doorOpen, busy}, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
